pixel_write_master: RTL
=======================

Name: pixel_write_master

Overview:
- Sits downstream of the Julia pixel engine and upstream of the Avalon-MM master port to SDRAM.
- Accepts pixel write beats (byte offset, data, last flag) over a valid/ready handshake.
- Buffers the beats in a FIFO and issues them as single Avalon writes at BASE_ADDR + offset, obeying master_waitrequest.
- Reports frame completion, beat count and fill level to the CSR block.

Parameters:
ADDRWIDTH, 32, master address and offset width
DATAWIDTH, 32, pixel data width
FIFO_AW, 4, log2 of FIFO depth (depth 16)
BASE_ADDR, 32'h08000000, SDRAM base added to every offset

Ports:
clk  in  1  system clock
reset_n  in  1  reset; synchronous, active-low
clear  in  1  synchronous flush/restart pulse from CSR logic
in_valid  in  1  beat offered by pixel engine
in_ready  out  1  beat accepted when in_valid && in_ready
in_offset  in  ADDRWIDTH  byte offset of pixel
in_data  in  DATAWIDTH  pixel data
in_last  in  1  final beat of frame
master_address  out  ADDRWIDTH  Avalon write address
master_writedata  out  DATAWIDTH  Avalon write data
master_write  out  1  Avalon write request
master_waitrequest  in  1  Avalon stall
busy  out  1  high in RUN or DRAIN, or while a beat is pending
done  out  1  frame fully written; sticky
write_count  out  32  Avalon writes completed since reset/clear
fill_level  out  FIFO_AW+1  FIFO occupancy (0..16), output register excluded

Behaviour:
- Reset (reset_n low at a clk edge) clears everything:
  - state IDLE; FIFO empty; output register empty.
  - master_write 0; master_address 0; master_writedata 0.
  - done 0; busy 0; write_count 0; fill_level 0.
  - in_ready is 0 during reset and 1 on the first cycle after reset.
- Storage: 16-entry FIFO holding {BASE_ADDR+in_offset, in_data, in_last}.
  - The address sum is computed at push time, truncated modulo 2^ADDRWIDTH.
  - The FIFO feeds a single output register that drives the master_* outputs.
  - Total capacity is 17 beats.
- in_ready = !FIFO_full && state in {IDLE, RUN}.
- Push/pop: the FIFO may push and pop in the same cycle. The occupancy is then unchanged.
- Output register loads from the FIFO head when it is empty, or when its current beat is accepted (master_write && !master_waitrequest).
  - Bypass: if the FIFO is empty, an accepted input beat loads the output register directly.
  - Min latency: accepted at edge N gives master_write=1 in the cycle after edge N.
- Avalon rule: while master_write && master_waitrequest, master_address, master_writedata and master_write stay constant.
  - Back-to-back beats issue with no idle cycle when data is available.
- write_count increments by 1 on every accepted Avalon write and wraps at 2^32.
- State machine:
  - IDLE: the first accepted beat goes to RUN. If that beat has in_last=1, go directly to DRAIN.
  - RUN: an accepted beat with in_last=1 goes to DRAIN. in_ready drops the following cycle.
  - DRAIN: go to DONE on the cycle the Avalon write of the last-flagged beat is accepted.
  - DONE: done=1 and in_ready=0; remain in DONE until clear or reset.
- clear has priority over the input handshake (no beat is accepted that cycle). On clear:
  - FIFO emptied; fill_level 0; done 0; write_count 0; state IDLE.
  - If the output register holds a beat with master_write=1, that beat is kept and completes normally.
  - The completing beat's acceptance does not increment write_count.
  - in_ready stays 0 and busy stays 1 until that beat is accepted.
- Reset mid-transfer: master_write drops immediately. Losing the in-flight beat is permitted on reset only.
- busy = (state in {RUN, DRAIN}) || output register valid.

Test Plan:
- Single beat: in_offset=0x40, in_data=0xAABBCCDD, in_last=1, waitrequest=0 -> master_write one cycle later with address 0x08000040 and data 0xAABBCCDD. Next cycle: done=1, write_count=1.
- Backpressure: waitrequest=1 for 5 cycles on the first beat -> address and data held stable 5 cycles. Write accepted on cycle 6, with write_count=1 only then.
- Fill: waitrequest=1, offer 20 beats -> 17 accepted, fill_level=16, in_ready=0. Release waitrequest -> 17 writes in order on consecutive cycles, then fill_level=0.
- Frame: 8 beats, offsets 0,4,...,28, last on beat 8, waitrequest toggling every cycle -> 8 writes in order. done rises on the acceptance of address 0x0800001C; in_ready stays 0 after last.
- Clear mid-stall: 5 beats queued, waitrequest=1, pulse clear -> fill_level=0 next cycle and the pending beat is held. On waitrequest=0 it completes, write_count=0, state IDLE, in_ready=1.
- Reset mid-frame: reset_n low for one edge during RUN -> all outputs at reset values next cycle. A new single-beat frame then completes normally.

Source files
------------

// File: rtl/pixel_write_master.sv
// pixel_write_master
// Takes pixel write beats (byte offset, data, last flag) from the Julia pixel
// engine, queues them in a 16-entry FIFO in front of a single output register
// and issues each one as a single Avalon-MM write at BASE_ADDR + offset.
// Frame completion, the number of completed writes and the FIFO fill level
// are reported for the CSR block.
//
// Ports:
//   clk                 system clock
//   reset_n             synchronous active-low reset
//   clear               synchronous flush/restart pulse
//   in_valid/in_ready   beat handshake from the pixel engine
//   in_offset/in_data   byte offset and pixel data of the beat
//   in_last             final beat of the frame
//   master_address      Avalon write address
//   master_writedata    Avalon write data
//   master_write        Avalon write request
//   master_waitrequest  Avalon stall
//   busy                frame in progress or a write still pending
//   done                frame fully written (sticky until clear/reset)
//   write_count         Avalon writes completed since reset/clear
//   fill_level          FIFO occupancy, output register not included
module pixel_write_master #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int FIFO_AW   = 4,
    parameter logic [ADDRWIDTH-1:0] BASE_ADDR = ADDRWIDTH'(32'h0800_0000)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDRWIDTH-1:0] in_offset,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic [ADDRWIDTH-1:0] master_address,
    output logic [DATAWIDTH-1:0] master_writedata,
    output logic                 master_write,
    input  logic                 master_waitrequest,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          write_count,
    output logic [FIFO_AW:0]     fill_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = ADDRWIDTH + DATAWIDTH + 1;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // FIFO storage and pointers
    logic [EW-1:0]        mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_reg;
    logic [FIFO_AW-1:0]   rd_ptr_reg;
    logic [FIFO_AW:0]     count_reg;

    // Output register feeding the Avalon master
    logic                 out_valid_reg;
    logic [ADDRWIDTH-1:0] out_addr_reg;
    logic [DATAWIDTH-1:0] out_data_reg;
    logic                 out_last_reg;

    // Set when clear left a beat in the output register; that beat finishes
    // its write but belongs to the flushed frame, so it is not counted and
    // no new beats are taken until it is gone.
    logic                 clear_hold_reg;
    logic [31:0]          write_count_reg;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 in_fire;
    logic                 out_fire;
    logic                 out_free;
    logic                 pop;
    logic                 push;
    logic                 bypass;
    logic [ADDRWIDTH-1:0] in_addr;
    logic [EW-1:0]        in_entry;
    logic [EW-1:0]        head;

    assign fifo_full  = (count_reg == DEPTH_C);
    assign fifo_empty = (count_reg == '0);

    // reset_n and clear gate the handshake directly so no beat can slip in
    // during a reset or flush cycle.
    assign in_ready = reset_n && !clear && !clear_hold_reg && !fifo_full &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_RUN));
    assign in_fire  = in_valid && in_ready;

    assign out_fire = out_valid_reg && !master_waitrequest;
    assign out_free = !out_valid_reg || out_fire;

    // The output register refills from the FIFO head first; only when the
    // FIFO is empty can an incoming beat skip the FIFO.
    assign pop    = out_free && !fifo_empty && !clear;
    assign bypass = out_free && fifo_empty && in_fire;
    assign push   = in_fire && !bypass;

    // Address formed at push time, wrapping modulo 2^ADDRWIDTH.
    assign in_addr  = BASE_ADDR + in_offset;
    assign in_entry = {in_addr, in_data, in_last};
    assign head     = mem[rd_ptr_reg];

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (in_fire) state_next = in_last ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (in_fire && in_last) state_next = ST_DRAIN;
            ST_DRAIN: if (out_fire && out_last_reg) state_next = ST_DONE;
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    // FIFO memory: no reset, written only on push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            out_valid_reg   <= 1'b0;
            out_addr_reg    <= '0;
            out_data_reg    <= '0;
            out_last_reg    <= 1'b0;
            clear_hold_reg  <= 1'b0;
            write_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (clear) begin
                wr_ptr_reg      <= '0;
                rd_ptr_reg      <= '0;
                count_reg       <= '0;
                write_count_reg <= '0;
                // A beat already on the bus stays put until it is accepted.
                clear_hold_reg  <= out_valid_reg && !out_fire;
                if (out_fire) begin
                    out_valid_reg <= 1'b0;
                end
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (push && !pop) begin
                    count_reg <= count_reg + 1'b1;
                end else if (pop && !push) begin
                    count_reg <= count_reg - 1'b1;
                end

                if (out_fire) begin
                    if (clear_hold_reg) begin
                        clear_hold_reg <= 1'b0;
                    end else begin
                        write_count_reg <= write_count_reg + 32'd1;
                    end
                end

                if (pop) begin
                    out_valid_reg <= 1'b1;
                    out_addr_reg  <= head[EW-1 -: ADDRWIDTH];
                    out_data_reg  <= head[DATAWIDTH:1];
                    out_last_reg  <= head[0];
                end else if (bypass) begin
                    out_valid_reg <= 1'b1;
                    out_addr_reg  <= in_addr;
                    out_data_reg  <= in_data;
                    out_last_reg  <= in_last;
                end else if (out_fire) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign master_write     = out_valid_reg;
    assign master_address   = out_addr_reg;
    assign master_writedata = out_data_reg;
    assign busy             = (state_reg == ST_RUN) || (state_reg == ST_DRAIN) || out_valid_reg;
    assign done             = (state_reg == ST_DONE);
    assign write_count      = write_count_reg;
    assign fill_level       = count_reg;

endmodule
